// File: rtl/imm_alu_sequencer_pkg.sv
// Shared encodings for the multi-cycle RISC control path.
// Holds the opcode constants, the ALU operation encoding, the PC source select
// encoding, the sequencer state enum and the decoded-control bundle. The ALU and
// the datapath muxes use these same encodings.
package imm_alu_sequencer_pkg;

    localparam int OPCODE_W = 6;
    localparam int ALU_OP_W = 3;
    localparam int FUNCT_W  = 3;

    localparam logic [OPCODE_W-1:0] OPC_R    = 6'h00;
    localparam logic [OPCODE_W-1:0] OPC_ADDI = 6'h01;
    localparam logic [OPCODE_W-1:0] OPC_ANDI = 6'h02;
    localparam logic [OPCODE_W-1:0] OPC_ORI  = 6'h03;
    localparam logic [OPCODE_W-1:0] OPC_LW   = 6'h04;
    localparam logic [OPCODE_W-1:0] OPC_SW   = 6'h05;
    localparam logic [OPCODE_W-1:0] OPC_BEQ  = 6'h06;
    localparam logic [OPCODE_W-1:0] OPC_J    = 6'h07;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_SRC_SEQ    = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2
    } pc_src_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
    } state_e;

    typedef struct packed {
        logic    sign_extend;
        logic    alu_src_imm;
        alu_op_e alu_op;
        logic    is_mem;
        logic    is_load;
        logic    is_branch;
        logic    is_jump;
        logic    illegal;
    } dec_t;

    // funct values 6 and 7 have no ALU operation behind them.
    function automatic logic funct_is_alu(input logic [FUNCT_W-1:0] funct);
        return funct <= 3'd5;
    endfunction

endpackage

// File: rtl/imm_op_decode.sv
// Combinational instruction decoder.
// Maps the latched opcode/funct pair to the static control bundle used by the
// sequencer: extender select, ALU operand/op select and instruction class flags.
// Ports:
//   opcode_i  latched opcode field
//   funct_i   latched R-type funct field
//   dec_o     decoded control bundle (dec_t)
module imm_op_decode
    import imm_alu_sequencer_pkg::*;
#(
    parameter int OPC_W = OPCODE_W
) (
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    output dec_t               dec_o
);

    always_comb begin
        dec_o        = '0;
        dec_o.alu_op = ALU_ADD;
        case (opcode_i)
            OPC_R: begin
                if (funct_is_alu(funct_i)) begin
                    dec_o.alu_op = alu_op_e'(funct_i);
                end else begin
                    dec_o.illegal = 1'b1;
                end
            end
            OPC_ADDI: begin
                dec_o.sign_extend = 1'b1;
                dec_o.alu_src_imm = 1'b1;
            end
            OPC_ANDI: begin
                dec_o.alu_src_imm = 1'b1;
                dec_o.alu_op      = ALU_AND;
            end
            OPC_ORI: begin
                dec_o.alu_src_imm = 1'b1;
                dec_o.alu_op      = ALU_OR;
            end
            OPC_LW: begin
                dec_o.sign_extend = 1'b1;
                dec_o.alu_src_imm = 1'b1;
                dec_o.is_mem      = 1'b1;
                dec_o.is_load     = 1'b1;
            end
            OPC_SW: begin
                dec_o.sign_extend = 1'b1;
                dec_o.alu_src_imm = 1'b1;
                dec_o.is_mem      = 1'b1;
            end
            OPC_BEQ: begin
                dec_o.sign_extend = 1'b1;
                dec_o.alu_op      = ALU_SUB;
                dec_o.is_branch   = 1'b1;
            end
            OPC_J: begin
                dec_o.is_jump = 1'b1;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_alu_sequencer.sv
// Multi-cycle control FSM for the single-ALU RISC datapath.
// Latches each fetched opcode/funct and steps FETCH/DECODE/EXEC/MEM/WB, driving
// the immediate extender select, ALU selects, memory strobes and PC/IR/register
// write enables.
// Ports:
//   clk_i, reset_n_i       clock (rising edge), asynchronous active-low reset
//   run_i                  start request, only looked at in IDLE
//   opcode_i, funct_i      instruction fields, valid while mem_ready_i=1 in FETCH
//   zero_flag_i            ALU zero result, used by BEQ in EXEC
//   mem_ready_i            memory access completes this cycle
//   mem_rd_o, mem_wr_o     memory strobes
//   ir_write_o             instruction register load
//   pc_write_o, pc_src_o   PC update enable and source select
//   sign_extend_o          extender select, 1 = sign extension
//   alu_src_imm_o, alu_op_o ALU operand B select and operation
//   reg_write_o, wb_sel_mem_o register write enable and writeback source
//   illegal_op_o           undefined-opcode pulse in DECODE
//   busy_o                 high outside IDLE
//
// state  | meaning
// IDLE   | waiting for run_i after reset
// FETCH  | instruction read in flight; IR/PC/opcode load on mem_ready_i
// DECODE | classify latched opcode; J and illegal opcodes finish here
// EXEC   | ALU operation; BEQ resolves and finishes here
// MEM    | LW/SW data access, ALU controls held for the address
// WB     | single-cycle register write
module imm_alu_sequencer
    import imm_alu_sequencer_pkg::*;
#(
    parameter int OPC_W   = OPCODE_W,
    parameter int ALUOP_W = ALU_OP_W
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               run_i,
    input  logic [OPC_W-1:0]   opcode_i,
    input  logic [FUNCT_W-1:0] funct_i,
    input  logic               zero_flag_i,
    input  logic               mem_ready_i,
    output logic               mem_rd_o,
    output logic               mem_wr_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic [1:0]         pc_src_o,
    output logic               sign_extend_o,
    output logic               alu_src_imm_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic               reg_write_o,
    output logic               wb_sel_mem_o,
    output logic               illegal_op_o,
    output logic               busy_o
);

    state_e             state_q, state_d;
    logic [OPC_W-1:0]   opcode_q;
    logic [FUNCT_W-1:0] funct_q;
    dec_t               dec;
    logic               fetch_done;
    pc_src_e            pc_src;
    alu_op_e            alu_op;

    assign fetch_done = (state_q == ST_FETCH) && mem_ready_i;

    imm_op_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opcode_i (opcode_q),
        .funct_i  (funct_q),
        .dec_o    (dec)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= ST_IDLE;
            opcode_q <= '0;
            funct_q  <= '0;
        end else begin
            state_q <= state_d;
            if (fetch_done) begin
                opcode_q <= opcode_i;
                funct_q  <= funct_i;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (run_i) state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready_i) state_d = ST_DECODE;
            ST_DECODE: state_d = (dec.illegal || dec.is_jump) ? ST_FETCH : ST_EXEC;
            ST_EXEC: begin
                if (dec.is_branch)   state_d = ST_FETCH;
                else if (dec.is_mem) state_d = ST_MEM;
                else                 state_d = ST_WB;
            end
            ST_MEM:    if (mem_ready_i) state_d = dec.is_load ? ST_WB : ST_FETCH;
            ST_WB:     state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Everything is decoded from state_q and the latched fields, except the
    // handshake-qualified strobes: IR/PC load on mem_ready_i in FETCH (the
    // instruction word only exists in that cycle) and the BEQ taken PC write
    // on zero_flag_i in EXEC (the compare result only exists in that cycle).
    always_comb begin
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        ir_write_o    = 1'b0;
        pc_write_o    = 1'b0;
        pc_src        = PC_SRC_SEQ;
        sign_extend_o = 1'b0;
        alu_src_imm_o = 1'b0;
        alu_op        = ALU_ADD;
        reg_write_o   = 1'b0;
        wb_sel_mem_o  = 1'b0;
        illegal_op_o  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_rd_o = 1'b1;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                end
            end
            ST_DECODE: begin
                sign_extend_o = dec.sign_extend;
                if (dec.illegal) begin
                    illegal_op_o = 1'b1;
                end else if (dec.is_jump) begin
                    pc_write_o = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                end
            end
            ST_EXEC: begin
                sign_extend_o = dec.sign_extend;
                alu_src_imm_o = dec.alu_src_imm;
                alu_op        = dec.alu_op;
                if (dec.is_branch) begin
                    pc_src     = PC_SRC_BRANCH;
                    pc_write_o = zero_flag_i;
                end
            end
            ST_MEM: begin
                sign_extend_o = dec.sign_extend;
                alu_src_imm_o = dec.alu_src_imm;
                alu_op        = dec.alu_op;
                mem_rd_o      = dec.is_load;
                mem_wr_o      = !dec.is_load;
            end
            ST_WB: begin
                sign_extend_o = dec.sign_extend;
                reg_write_o   = 1'b1;
                wb_sel_mem_o  = dec.is_load;
            end
            default: ;
        endcase
    end

    assign pc_src_o = pc_src;
    assign alu_op_o = ALUOP_W'(alu_op);
    assign busy_o   = (state_q != ST_IDLE);

endmodule
